wbu_commit: RTL

Write-back/commit stage of the multi-cycle NPC core. Accepts one completed instruction packet from LSU over a valid/ready handshake and commits it in one cycle: GPR write, plus CSR write / ecall trap strobes into the CSR file. It then hands the resolved next PC to IFU over a second valid/ready handshake. It also issues the boot PC after reset and halts the core on ebreak.

---
 rtl/wbu_commit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/wbu_commit.sv
// rtl/wbu_commit.sv - write-back/commit stage: GPR/CSR commit strobes and next-PC hand-off to IFU
//
// Optional feature macro: WBU_PERF_EN (64-bit retired-instruction counter on retire_cnt).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      packet handshake from LSU
//   in_pc .. in_is_ebreak    completed-instruction packet fields
//   rf_wen/rf_waddr/rf_wdata GPR write port (strobe only in the commit cycle)
//   valid_wbu, csr_*         commit strobe and CSR write port into the CSR file
//   is_ecall_wbu/is_mret_wbu trap / return strobes; commit_pc feeds mepc
//   out_valid/out_ready/out_pc next-PC handshake to IFU (boot PC after reset)
//   halt                     sticky once an ebreak commits; cleared only by rst
//   retire_cnt               retired-instruction count (0 when WBU_PERF_EN is undefined)

module wbu_commit #(
   parameter int                      DATA_WIDTH     = 32,
   parameter int                      CSR_ADDR_WIDTH = 12,
   parameter int                      RF_ADDR_WIDTH  = 5,
   parameter logic [DATA_WIDTH-1:0]   RESET_PC       = 32'h8000_0000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_pc,
   input  logic [DATA_WIDTH-1:0]     in_dnpc,
   input  logic                      in_rf_wen,
   input  logic [RF_ADDR_WIDTH-1:0]  in_rd,
   input  logic [DATA_WIDTH-1:0]     in_rd_wdata,
   input  logic                      in_csr_wen,
   input  logic [CSR_ADDR_WIDTH-1:0] in_csr_waddr,
   input  logic [DATA_WIDTH-1:0]     in_csr_wdata,
   input  logic                      in_is_ecall,
   input  logic                      in_is_mret,
   input  logic                      in_is_ebreak,
   output logic                      rf_wen,
   output logic [RF_ADDR_WIDTH-1:0]  rf_waddr,
   output logic [DATA_WIDTH-1:0]     rf_wdata,
   output logic                      valid_wbu,
   output logic                      csr_wen,
   output logic [CSR_ADDR_WIDTH-1:0] csr_waddr,
   output logic [DATA_WIDTH-1:0]     csr_wdata,
   output logic                      is_ecall_wbu,
   output logic                      is_mret_wbu,
   output logic [DATA_WIDTH-1:0]     commit_pc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_pc,
   output logic                      halt,
   output logic [63:0]               retire_cnt
);

   typedef enum logic [2:0] {
      BOOT     = 3'd0,
      IDLE     = 3'd1,
      COMMIT   = 3'd2,
      REDIRECT = 3'd3,
      HALT     = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [DATA_WIDTH-1:0]     pc_q;
   logic [DATA_WIDTH-1:0]     dnpc_q;
   logic                      rf_wen_q;
   logic [RF_ADDR_WIDTH-1:0]  rd_q;
   logic [DATA_WIDTH-1:0]     rd_wdata_q;
   logic                      csr_wen_q;
   logic [CSR_ADDR_WIDTH-1:0] csr_waddr_q;
   logic [DATA_WIDTH-1:0]     csr_wdata_q;
   logic                      ecall_q;
   logic                      mret_q;
   logic                      ebreak_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BOOT;
         pc_q        <= '0;
         dnpc_q      <= '0;
         rf_wen_q    <= 1'b0;
         rd_q        <= '0;
         rd_wdata_q  <= '0;
         csr_wen_q   <= 1'b0;
         csr_waddr_q <= '0;
         csr_wdata_q <= '0;
         ecall_q     <= 1'b0;
         mret_q      <= 1'b0;
         ebreak_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && in_valid) begin
            pc_q        <= in_pc;
            dnpc_q      <= in_dnpc;
            rf_wen_q    <= in_rf_wen;
            rd_q        <= in_rd;
            rd_wdata_q  <= in_rd_wdata;
            csr_wen_q   <= in_csr_wen;
            csr_waddr_q <= in_csr_waddr;
            csr_wdata_q <= in_csr_wdata;
            ecall_q     <= in_is_ecall;
            mret_q      <= in_is_mret;
            ebreak_q    <= in_is_ebreak;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      out_pc       = dnpc_q;
      valid_wbu    = 1'b0;
      rf_wen       = 1'b0;
      csr_wen      = 1'b0;
      is_ecall_wbu = 1'b0;
      is_mret_wbu  = 1'b0;
      halt         = 1'b0;
      case (state)
         BOOT: begin
            out_valid = 1'b1;
            out_pc    = RESET_PC;
            if (out_ready) state_nxt = IDLE;
         end
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = COMMIT;
         end
         COMMIT: begin
            valid_wbu = 1'b1;
            if (ebreak_q) begin
               // ebreak commits (and retires) but writes nothing architectural.
               state_nxt = HALT;
            end else begin
               // x0 is hardwired to zero; ecall wins over a CSR write in the same packet.
               rf_wen       = rf_wen_q && (rd_q != '0);
               csr_wen      = csr_wen_q && !ecall_q;
               is_ecall_wbu = ecall_q;
               is_mret_wbu  = mret_q;
               state_nxt    = REDIRECT;
            end
         end
         REDIRECT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         HALT: begin
            halt = 1'b1;
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

   assign rf_waddr  = rd_q;
   assign rf_wdata  = rd_wdata_q;
   assign csr_waddr = csr_waddr_q;
   assign csr_wdata = csr_wdata_q;
   assign commit_pc = pc_q;

`ifdef WBU_PERF_EN
   logic [63:0] retire_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         retire_cnt_q <= '0;
      end else if (state == COMMIT) begin
         retire_cnt_q <= retire_cnt_q + 64'd1;
      end
   end

   assign retire_cnt = retire_cnt_q;
`else
   assign retire_cnt = '0;
`endif

endmodule
